// File: rtl/param_universal_shifter.sv
// param_universal_shifter: parametrised universal shift register with
// hold/load/clear, logical/rotate/arithmetic shifts, and multi-bit shift
// bursts (one bit per clock) under a valid/ready command handshake.
//
// Ports:
//   clk, reset_n   clock (rising edge), asynchronous active-low reset
//   clear          synchronous abort: zero register, return to IDLE, no done
//   cmd_valid      command present
//   cmd_ready      command can be accepted (= !busy)
//   mode           000 HOLD 001 SHR 010 SHL 011 ROR 100 ROL 101 ASR 110 LOAD 111 CLR
//   amount         number of single-bit shifts for shift modes
//   din            parallel load data
//   rsi / lsi      serial inputs entering MSB on SHR / LSB on SHL
//   qout           register contents
//   so_bit         last bit shifted or rotated out
//   busy           shift burst in progress
//   done           one-cycle completion pulse
module param_universal_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  input  logic             rsi,
  input  logic             lsi,
  output logic [WIDTH-1:0] qout,
  output logic             so_bit,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ASR  = 3'b101;
  localparam logic [2:0] M_LOAD = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  // Two-bit encoding so that the unused codes fall back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SHIFT = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             so_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       mode_r, mode_nxt;
  logic [WIDTH:0]   step;

  assign cmd_ready = ~busy;

  // One single-bit shift of the current contents; result is {so_bit, q}.
  function automatic logic [WIDTH:0] shift1(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic             so_cur,
    input logic             r,
    input logic             l
  );
    logic [WIDTH:0] res;
    case (m)
      M_SHR:   res = {v[0],       r,          v[WIDTH-1:1]};
      M_SHL:   res = {v[WIDTH-1], v[WIDTH-2:0], l};
      M_ROR:   res = {v[0],       v[0],       v[WIDTH-1:1]};
      M_ROL:   res = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      M_ASR:   res = {v[0],       v[WIDTH-1], v[WIDTH-1:1]};
      default: res = {so_cur, v};
    endcase
    return res;
  endfunction

  assign step = shift1(mode_r, qout, so_bit, rsi, lsi);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    q_nxt     = qout;
    so_nxt    = so_bit;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    cnt_nxt   = cnt;
    mode_nxt  = mode_r;

    if (clear) begin
      state_nxt = IDLE;
      q_nxt     = '0;
      so_nxt    = 1'b0;
      busy_nxt  = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          busy_nxt = 1'b0;
          if (cmd_valid && !busy) begin
            case (mode)
              M_HOLD: done_nxt = 1'b1;
              M_LOAD: begin
                q_nxt    = din;
                done_nxt = 1'b1;
              end
              M_CLR: begin
                q_nxt    = '0;
                done_nxt = 1'b1;
              end
              default: begin
                if (amount == '0) begin
                  done_nxt = 1'b1;
                end else begin
                  mode_nxt  = mode;
                  cnt_nxt   = amount;
                  state_nxt = SHIFT;
                  busy_nxt  = 1'b1;
                end
              end
            endcase
          end
        end
        SHIFT: begin
          {so_nxt, q_nxt} = step;
          cnt_nxt         = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      qout   <= '0;
      so_bit <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      mode_r <= M_HOLD;
    end else begin
      state  <= state_nxt;
      qout   <= q_nxt;
      so_bit <= so_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      cnt    <= cnt_nxt;
      mode_r <= mode_nxt;
    end
  end

endmodule

// File: tb/tb_param_universal_shifter.sv
// Self-checking bench for param_universal_shifter (WIDTH=8, CNT_W=4):
// table of directed commands plus hand sequences for handshake, abort, reset.
module tb_param_universal_shifter;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ASR  = 3'b101;
  localparam logic [2:0] M_LOAD = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] mode;
  logic [3:0] amount;
  logic [7:0] din;
  logic       rsi;
  logic       lsi;
  logic [7:0] qout;
  logic       so_bit;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_universal_shifter #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .mode      (mode),
    .amount    (amount),
    .din       (din),
    .rsi       (rsi),
    .lsi       (lsi),
    .qout      (qout),
    .so_bit    (so_bit),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    string      name;
    logic [7:0] pre;
    logic [2:0] mode;
    logic [3:0] amt;
    logic [7:0] din;
    logic       rsi;
    logic       lsi;
    logic [7:0] exp_q;
    logic       exp_so;
    logic       chk_so;
    int         exp_lat;
    int         exp_busy;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command at the current cycle and wait (bounded) for done.
  task automatic run_cmd(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d,
                         input logic r, input logic l, output int lat, output int bc);
    mode      = m;
    amount    = a;
    din       = d;
    rsi       = r;
    lsi       = l;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    bc  = 0;
    while (!done && lat < 64) begin
      if (busy) bc++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bc;

    vecs[0]  = '{"load",     8'h00, M_LOAD, 4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1,  0};
    vecs[1]  = '{"hold",     8'h5A, M_HOLD, 4'd0,  8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1,  0};
    vecs[2]  = '{"clr",      8'h5A, M_CLR,  4'd0,  8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1,  0};
    vecs[3]  = '{"ror3",     8'h81, M_ROR,  4'd3,  8'h00, 1'b0, 1'b0, 8'h30, 1'b0, 1'b1, 4,  3};
    vecs[4]  = '{"rol9",     8'h81, M_ROL,  4'd9,  8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b1, 10, 9};
    vecs[5]  = '{"shr4",     8'h00, M_SHR,  4'd4,  8'h00, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b1, 5,  4};
    vecs[6]  = '{"shl2",     8'hFF, M_SHL,  4'd2,  8'h00, 1'b0, 1'b0, 8'hFC, 1'b1, 1'b1, 3,  2};
    vecs[7]  = '{"shr_amt0", 8'h3C, M_SHR,  4'd0,  8'h00, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1,  0};
    vecs[8]  = '{"asr3",     8'h80, M_ASR,  4'd3,  8'h00, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b1, 4,  3};
    vecs[9]  = '{"ror15",    8'h81, M_ROR,  4'd15, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 16, 15};
    vecs[10] = '{"shl10",    8'h00, M_SHL,  4'd10, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 11, 10};
    vecs[11] = '{"asr12",    8'h90, M_ASR,  4'd12, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 13, 12};

    reset_n = 1'b0; clear = 1'b0; cmd_valid = 1'b0;
    mode = M_HOLD; amount = 4'd0; din = 8'h00; rsi = 1'b0; lsi = 1'b0;
    #12;
    chk("rst_q", 32'(qout), 32'h0);
    chk("rst_so", 32'(so_bit), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset_n = 1'b1;
    tick();
    chk("rst_ready", 32'(cmd_ready), 32'h1);

    // Table-driven commands, each preceded by a LOAD of the start value.
    for (int i = 0; i < 12; i++) begin
      run_cmd(M_LOAD, 4'd0, vecs[i].pre, 1'b0, 1'b0, lat, bc);
      run_cmd(vecs[i].mode, vecs[i].amt, vecs[i].din, vecs[i].rsi, vecs[i].lsi, lat, bc);
      chk({vecs[i].name, "_q"}, 32'(qout), 32'(vecs[i].exp_q));
      if (vecs[i].chk_so) chk({vecs[i].name, "_so"}, 32'(so_bit), 32'(vecs[i].exp_so));
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      chk({vecs[i].name, "_busy"}, 32'(bc), 32'(vecs[i].exp_busy));
      tick();
      chk({vecs[i].name, "_done_once"}, 32'(done), 32'h0);
    end

    // cmd_valid held through a burst: LOAD not taken until the done cycle.
    run_cmd(M_LOAD, 4'd0, 8'h81, 1'b0, 1'b0, lat, bc);
    mode = M_ROR; amount = 4'd3; cmd_valid = 1'b1;
    tick();
    mode = M_LOAD; din = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      chk("held_ready", 32'(cmd_ready), 32'h0);
      chk("held_done", 32'(done), 32'h0);
      tick();
    end
    chk("held_done_q", 32'(qout), 32'h30);
    chk("held_done_pulse", 32'(done), 32'h1);
    tick();
    cmd_valid = 1'b0;
    chk("held_load_q", 32'(qout), 32'hEE);
    chk("held_load_done", 32'(done), 32'h1);
    tick();

    // Back-to-back LOAD then SHL k=1 with no idle cycle.
    mode = M_LOAD; din = 8'h81; cmd_valid = 1'b1;
    tick();
    chk("b2b_load_q", 32'(qout), 32'h81);
    chk("b2b_load_done", 32'(done), 32'h1);
    mode = M_SHL; amount = 4'd1; lsi = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("b2b_shl_busy", 32'(busy), 32'h1);
    tick();
    chk("b2b_shl_q", 32'(qout), 32'h03);
    chk("b2b_shl_so", 32'(so_bit), 32'h1);
    chk("b2b_shl_done", 32'(done), 32'h1);
    lsi = 1'b0;
    tick();

    // Abort: clear during the second burst cycle of SHR k=5.
    run_cmd(M_LOAD, 4'd0, 8'hFF, 1'b0, 1'b0, lat, bc);
    mode = M_SHR; amount = 4'd5; rsi = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("abort_mid_q", 32'(qout), 32'h7F);
    clear = 1'b1; mode = M_LOAD; din = 8'h55; cmd_valid = 1'b1;
    tick();
    clear = 1'b0; cmd_valid = 1'b0;
    chk("abort_q", 32'(qout), 32'h0);
    chk("abort_so", 32'(so_bit), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'h0);
      chk("abort_q_stays", 32'(qout), 32'h0);
    end
    run_cmd(M_LOAD, 4'd0, 8'h42, 1'b0, 1'b0, lat, bc);
    chk("abort_next_q", 32'(qout), 32'h42);
    chk("abort_next_lat", 32'(lat), 32'd1);
    tick();

    // Asynchronous reset in the middle of a burst.
    run_cmd(M_LOAD, 4'd0, 8'h0F, 1'b0, 1'b0, lat, bc);
    mode = M_SHR; amount = 4'd5; rsi = 1'b1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("rstmid_busy_before", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_q", 32'(qout), 32'h0);
    chk("rstmid_so", 32'(so_bit), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_done", 32'(done), 32'h0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("rstmid_ready", 32'(cmd_ready), 32'h1);
    chk("rstmid_q_after", 32'(qout), 32'h0);
    run_cmd(M_LOAD, 4'd0, 8'h66, 1'b0, 1'b0, lat, bc);
    chk("rstmid_next_q", 32'(qout), 32'h66);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
